// File: rtl/udma_uart_cfg_arb.sv
// Two-requester round-robin arbiter in front of a single UART cfg register port.
// One downstream access per accepted request, with optional grant locking.
module udma_uart_cfg_arb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              req0_valid_i,
    input  logic              req0_rwn_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    input  logic              req0_lock_i,
    output logic              req0_ready_o,
    output logic [DATA_W-1:0] req0_data_o,

    input  logic              req1_valid_i,
    input  logic              req1_rwn_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    input  logic              req1_lock_i,
    output logic              req1_ready_o,
    output logic [DATA_W-1:0] req1_data_o,

    output logic              cfg_valid_o,
    output logic              cfg_rwn_o,
    output logic [ADDR_W-1:0] cfg_addr_o,
    output logic [DATA_W-1:0] cfg_data_o,
    input  logic              cfg_ready_i,
    input  logic [DATA_W-1:0] cfg_data_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                       state_reg, state_next;
    logic                         rwn_reg, rwn_next;
    logic [ADDR_W-1:0]            addr_reg, addr_next;
    logic [DATA_W-1:0]            wdata_reg, wdata_next;
    logic                         gnt_reg, gnt_next;
    logic                         rr_ptr_reg, rr_ptr_next;
    logic                         lock_act_reg, lock_act_next;
    logic                         lock_id_reg, lock_id_next;
    logic [1:0][DATA_W-1:0]       rdata_reg, rdata_next;

    logic [1:0]                   valid_vec, lock_vec, rwn_vec, elig, ready_vec;
    logic [1:0][ADDR_W-1:0]       addr_vec;
    logic [1:0][DATA_W-1:0]       data_vec;
    logic                         any_elig, winner;

    assign valid_vec = {req1_valid_i, req0_valid_i};
    assign lock_vec  = {req1_lock_i,  req0_lock_i};
    assign rwn_vec   = {req1_rwn_i,   req0_rwn_i};
    assign addr_vec  = {req1_addr_i,  req0_addr_i};
    assign data_vec  = {req1_data_i,  req0_data_i};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            // While a lock is held only its owner may compete.
            assign elig[gi]      = valid_vec[gi] & (~lock_act_reg | (lock_id_reg == 1'(gi)));
            assign ready_vec[gi] = (state_reg == ST_RESP) && (gnt_reg == 1'(gi));
        end
    endgenerate

    assign any_elig = |elig;
    assign winner   = (&elig) ? rr_ptr_reg : elig[1];

    always_comb begin
        state_next    = state_reg;
        rwn_next      = rwn_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        gnt_next      = gnt_reg;
        rr_ptr_next   = rr_ptr_reg;
        lock_act_next = lock_act_reg;
        lock_id_next  = lock_id_reg;
        rdata_next    = rdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_elig) begin
                    state_next = ST_ISSUE;
                    rwn_next   = rwn_vec[winner];
                    addr_next  = addr_vec[winner];
                    wdata_next = data_vec[winner];
                    gnt_next   = winner;
                    if (!lock_act_reg) begin
                        rr_ptr_next = ~winner;
                    end
                end else if (lock_act_reg && !valid_vec[lock_id_reg] && !lock_vec[lock_id_reg]) begin
                    lock_act_next = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (cfg_ready_i) begin
                    state_next          = ST_RESP;
                    rdata_next[gnt_reg] = rwn_reg ? cfg_data_i : '0;
                end
            end
            ST_RESP: begin
                state_next    = ST_IDLE;
                lock_act_next = lock_vec[gnt_reg];
                lock_id_next  = gnt_reg;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            rwn_reg      <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            gnt_reg      <= 1'b0;
            rr_ptr_reg   <= 1'b0;
            lock_act_reg <= 1'b0;
            lock_id_reg  <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            rwn_reg      <= rwn_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            gnt_reg      <= gnt_next;
            rr_ptr_reg   <= rr_ptr_next;
            lock_act_reg <= lock_act_next;
            lock_id_reg  <= lock_id_next;
            rdata_reg    <= rdata_next;
        end
    end

    assign cfg_valid_o  = (state_reg == ST_ISSUE);
    assign cfg_rwn_o    = rwn_reg;
    assign cfg_addr_o   = addr_reg;
    assign cfg_data_o   = wdata_reg;
    assign req0_ready_o = ready_vec[0];
    assign req1_ready_o = ready_vec[1];
    assign req0_data_o  = rdata_reg[0];
    assign req1_data_o  = rdata_reg[1];
    assign busy_o       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_udma_uart_cfg_arb.sv
// Directed bench for udma_uart_cfg_arb: reset, backpressure, write, round-robin,
// lock and mid-transfer reset scenarios with hand-computed expectations.
module tb_udma_uart_cfg_arb;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req0_rwn_i, req0_lock_i, req0_ready_o;
    logic [4:0]  req0_addr_i;
    logic [31:0] req0_data_i, req0_data_o;
    logic        req1_valid_i, req1_rwn_i, req1_lock_i, req1_ready_o;
    logic [4:0]  req1_addr_i;
    logic [31:0] req1_data_i, req1_data_o;
    logic        cfg_valid_o, cfg_rwn_o, cfg_ready_i, busy_o;
    logic [4:0]  cfg_addr_o;
    logic [31:0] cfg_data_o, cfg_data_i;

    int vectors     = 0;
    int miscompares = 0;
    int hs_count    = 0;
    int vld_count   = 0;

    udma_uart_cfg_arb #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_rwn_i   (req0_rwn_i),
        .req0_addr_i  (req0_addr_i),
        .req0_data_i  (req0_data_i),
        .req0_lock_i  (req0_lock_i),
        .req0_ready_o (req0_ready_o),
        .req0_data_o  (req0_data_o),
        .req1_valid_i (req1_valid_i),
        .req1_rwn_i   (req1_rwn_i),
        .req1_addr_i  (req1_addr_i),
        .req1_data_i  (req1_data_i),
        .req1_lock_i  (req1_lock_i),
        .req1_ready_o (req1_ready_o),
        .req1_data_o  (req1_data_o),
        .cfg_valid_o  (cfg_valid_o),
        .cfg_rwn_o    (cfg_rwn_o),
        .cfg_addr_o   (cfg_addr_o),
        .cfg_data_o   (cfg_data_o),
        .cfg_ready_i  (cfg_ready_i),
        .cfg_data_i   (cfg_data_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Downstream observer: valid cycles and accepted handshakes.
    always @(posedge clk) begin
        if (cfg_valid_o) vld_count++;
        if (cfg_valid_o && cfg_ready_i) hs_count++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req0_valid_i = 1'b0; req0_rwn_i = 1'b0; req0_addr_i = '0; req0_data_i = '0; req0_lock_i = 1'b0;
        req1_valid_i = 1'b0; req1_rwn_i = 1'b0; req1_addr_i = '0; req1_data_i = '0; req1_lock_i = 1'b0;
        cfg_ready_i  = 1'b0; cfg_data_i = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset;
        // Active inputs during reset must be ignored.
        idle_inputs();
        req0_valid_i = 1'b1; req1_valid_i = 1'b1; cfg_ready_i = 1'b1; cfg_data_i = 32'hFFFF_FFFF;
        rst_i = 1'b1;
        tick();
        tick();
        vectors++; if (cfg_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_valid got=%b exp=0", cfg_valid_o); end
        vectors++; if (cfg_rwn_o !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_rwn got=%b exp=0", cfg_rwn_o); end
        vectors++; if (cfg_addr_o !== 5'h00) begin miscompares++; $display("FAIL reset_cfg_addr got=%h exp=00", cfg_addr_o); end
        vectors++; if (cfg_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_cfg_data got=%h exp=0", cfg_data_o); end
        vectors++; if ({req1_ready_o, req0_ready_o} !== 2'b00) begin miscompares++; $display("FAIL reset_ready got=%b exp=00", {req1_ready_o, req0_ready_o}); end
        vectors++; if (req0_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_req0_data got=%h exp=0", req0_data_o); end
        vectors++; if (req1_data_o !== 32'h0) begin miscompares++; $display("FAIL reset_req1_data got=%h exp=0", req1_data_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        idle_inputs();
        rst_i = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_backpressure;
        int hs0, v0;
        hs0 = hs_count; v0 = vld_count;
        req0_valid_i = 1'b1; req0_rwn_i = 1'b1; req0_addr_i = 5'h0A; req0_data_i = 32'h0;
        cfg_ready_i = 1'b0; cfg_data_i = 32'hFFFF_FFFF;
        tick();
        for (int i = 0; i < 4; i++) begin
            vectors++; if ({cfg_valid_o, cfg_rwn_o, cfg_addr_o} !== {1'b1, 1'b1, 5'h0A}) begin miscompares++; $display("FAIL bp_stall_fields cyc=%0d got=%b_%b_%h exp=1_1_0a", i, cfg_valid_o, cfg_rwn_o, cfg_addr_o); end
            vectors++; if (req0_ready_o !== 1'b0) begin miscompares++; $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0", i, req0_ready_o); end
            tick();
        end
        cfg_ready_i = 1'b1; cfg_data_i = 32'h2;
        vectors++; if ({cfg_valid_o, cfg_rwn_o, cfg_addr_o} !== {1'b1, 1'b1, 5'h0A}) begin miscompares++; $display("FAIL bp_accept_fields got=%b_%b_%h exp=1_1_0a", cfg_valid_o, cfg_rwn_o, cfg_addr_o); end
        tick();
        vectors++; if (req0_ready_o !== 1'b1) begin miscompares++; $display("FAIL bp_resp_ready got=%b exp=1", req0_ready_o); end
        vectors++; if (req0_data_o !== 32'h2) begin miscompares++; $display("FAIL bp_resp_data got=%h exp=2", req0_data_o); end
        vectors++; if (cfg_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_resp_valid got=%b exp=0", cfg_valid_o); end
        idle_inputs();
        tick();
        vectors++; if ({req0_ready_o, busy_o} !== 2'b00) begin miscompares++; $display("FAIL bp_idle got=%b exp=00", {req0_ready_o, busy_o}); end
        vectors++; if (req0_data_o !== 32'h2) begin miscompares++; $display("FAIL bp_data_hold got=%h exp=2", req0_data_o); end
        tick();
        vectors++; if (hs_count - hs0 !== 1) begin miscompares++; $display("FAIL bp_handshakes got=%0d exp=1", hs_count - hs0); end
        vectors++; if (vld_count - v0 !== 5) begin miscompares++; $display("FAIL bp_valid_cycles got=%0d exp=5", vld_count - v0); end
        $display("test_backpressure done");
    endtask

    task automatic test_single_write;
        req0_valid_i = 1'b1; req0_rwn_i = 1'b0; req0_addr_i = 5'h09; req0_data_i = 32'h01B2_0306;
        cfg_ready_i = 1'b1; cfg_data_i = 32'hDEAD_BEEF;
        tick();
        vectors++; if ({cfg_valid_o, cfg_rwn_o, cfg_addr_o} !== {1'b1, 1'b0, 5'h09}) begin miscompares++; $display("FAIL wr_issue_fields got=%b_%b_%h exp=1_0_09", cfg_valid_o, cfg_rwn_o, cfg_addr_o); end
        vectors++; if (cfg_data_o !== 32'h01B2_0306) begin miscompares++; $display("FAIL wr_issue_data got=%h exp=01b20306", cfg_data_o); end
        vectors++; if (req0_ready_o !== 1'b0) begin miscompares++; $display("FAIL wr_issue_ready got=%b exp=0", req0_ready_o); end
        vectors++; if (req0_data_o !== 32'h2) begin miscompares++; $display("FAIL wr_prev_data_hold got=%h exp=2", req0_data_o); end
        tick();
        vectors++; if ({req1_ready_o, req0_ready_o, cfg_valid_o} !== 3'b010) begin miscompares++; $display("FAIL wr_resp got=%b exp=010", {req1_ready_o, req0_ready_o, cfg_valid_o}); end
        vectors++; if (req0_data_o !== 32'h0) begin miscompares++; $display("FAIL wr_resp_data got=%h exp=0", req0_data_o); end
        idle_inputs();
        tick();
        vectors++; if (req0_ready_o !== 1'b0) begin miscompares++; $display("FAIL wr_pulse_width got=%b exp=0", req0_ready_o); end
        $display("test_single_write done");
    endtask

    task automatic test_contention;
        int exp_w;
        do_reset();
        req0_valid_i = 1'b1; req0_addr_i = 5'd1; req0_data_i = 32'hA0;
        req1_valid_i = 1'b1; req1_addr_i = 5'd2; req1_data_i = 32'hB1;
        cfg_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_w = k % 2;
            tick();
            vectors++; if ({cfg_valid_o, cfg_addr_o} !== {1'b1, 5'(k + 1)}) begin miscompares++; $display("FAIL rr_issue k=%0d got=%b_%h exp=1_%h", k, cfg_valid_o, cfg_addr_o, 5'(k + 1)); end
            tick();
            vectors++; if ({req1_ready_o, req0_ready_o} !== ((exp_w == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rr_ready k=%0d got=%b exp_winner=%0d", k, {req1_ready_o, req0_ready_o}, exp_w); end
            if (exp_w == 0) req0_addr_i = 5'(k + 3);
            else            req1_addr_i = 5'(k + 3);
            tick();
            $display("rr transfer %0d winner req%0d", k, exp_w);
        end
        idle_inputs();
        tick();
        $display("test_contention done");
    endtask

    task automatic test_lock;
        do_reset();
        req0_valid_i = 1'b1; req0_rwn_i = 1'b0; req0_addr_i = 5'h00; req0_lock_i = 1'b1;
        req1_valid_i = 1'b1; req1_rwn_i = 1'b0; req1_addr_i = 5'h1F; req1_lock_i = 1'b0;
        cfg_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if ({cfg_valid_o, cfg_addr_o} !== {1'b1, 5'(k)}) begin miscompares++; $display("FAIL lock_issue k=%0d got=%b_%h exp=1_%h", k, cfg_valid_o, cfg_addr_o, 5'(k)); end
            if (k == 2) req0_lock_i = 1'b0;
            tick();
            vectors++; if ({req1_ready_o, req0_ready_o} !== 2'b01) begin miscompares++; $display("FAIL lock_ready k=%0d got=%b exp=01", k, {req1_ready_o, req0_ready_o}); end
            req0_addr_i = 5'(k + 1);
            if (k == 2) req0_valid_i = 1'b0;
            tick();
        end
        tick();
        vectors++; if ({cfg_valid_o, cfg_addr_o} !== {1'b1, 5'h1F}) begin miscompares++; $display("FAIL lock_release_issue got=%b_%h exp=1_1f", cfg_valid_o, cfg_addr_o); end
        tick();
        vectors++; if ({req1_ready_o, req0_ready_o} !== 2'b10) begin miscompares++; $display("FAIL lock_release_ready got=%b exp=10", {req1_ready_o, req0_ready_o}); end
        idle_inputs();
        tick();
        $display("test_lock done");
    endtask

    task automatic test_reset_issue;
        do_reset();
        req0_valid_i = 1'b1; req0_rwn_i = 1'b1; req0_addr_i = 5'h03;
        cfg_ready_i = 1'b0;
        tick();
        vectors++; if (cfg_valid_o !== 1'b1) begin miscompares++; $display("FAIL rsti_issue got=%b exp=1", cfg_valid_o); end
        rst_i = 1'b1;
        tick();
        vectors++; if ({cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o} !== 39'h0) begin miscompares++; $display("FAIL rsti_cfg got=%b_%b_%h_%h exp=0", cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o); end
        vectors++; if ({req1_ready_o, req0_ready_o, busy_o} !== 3'b000) begin miscompares++; $display("FAIL rsti_ready_busy got=%b exp=000", {req1_ready_o, req0_ready_o, busy_o}); end
        vectors++; if ({req0_data_o, req1_data_o} !== 64'h0) begin miscompares++; $display("FAIL rsti_data got=%h_%h exp=0", req0_data_o, req1_data_o); end
        rst_i = 1'b0;
        req1_valid_i = 1'b1; req1_rwn_i = 1'b1; req1_addr_i = 5'h07;
        cfg_ready_i = 1'b1; cfg_data_i = 32'h1234_5678;
        tick();
        vectors++; if ({cfg_valid_o, cfg_addr_o} !== {1'b1, 5'h03}) begin miscompares++; $display("FAIL rsti_rr_ptr got=%b_%h exp=1_03", cfg_valid_o, cfg_addr_o); end
        tick();
        vectors++; if ({req1_ready_o, req0_ready_o} !== 2'b01) begin miscompares++; $display("FAIL rsti_resp got=%b exp=01", {req1_ready_o, req0_ready_o}); end
        vectors++; if (req0_data_o !== 32'h1234_5678) begin miscompares++; $display("FAIL rsti_resp_data got=%h exp=12345678", req0_data_o); end
        idle_inputs();
        tick();
        $display("test_reset_issue done");
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_backpressure();
        test_single_write();
        test_contention();
        test_lock();
        test_reset_issue();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
